// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state encoding and timeout default for the memory access unit
package mem_access_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;
    localparam logic [7:0] TIMEOUT_DEF = 8'd255;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts memory wait cycles and flags the cycle in which the limit is reached
module wait_timer
    import mem_access_pkg::*;
#(
    parameter logic [7:0] LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    logic [7:0] count;
    logic [7:0] count_inc;

    assign count_inc = count + 8'd1;
    // expiry fires in the cycle whose increment would reach LIMIT, so a request waits exactly LIMIT cycles
    assign expired = en && (count_inc == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clear) count <= '0;
        else if (en) count <= count_inc;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding fetch/load/store controller with timeout and misalignment faults
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              load_req,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    state_t state, nxt;
    logic waiting, expired, data_req, misalign, acc, fault;

    assign busy     = state != IDLE;
    assign waiting  = state == FETCH || state == LOAD || state == STORE;
    assign data_req = store_req || load_req;
    assign misalign = data_req && data_addr[1:0] != 2'b00;
    assign acc      = state == IDLE && (data_req || fetch_req) && !misalign;
    assign fault    = (state == IDLE && misalign) || (waiting && expired);

    wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .en     (waiting && !mem_ready),
        .expired(expired)
    );

    always_comb begin
        nxt = state;
        if (acc) nxt = store_req ? STORE : load_req ? LOAD : FETCH;
        else if (waiting && (mem_ready || expired)) nxt = mem_ready ? DONE : IDLE;
        else if (state == DONE) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            instr     <= '0;
            old_pc    <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state   <= nxt;
            mem_req <= nxt == FETCH || nxt == LOAD || nxt == STORE;
            mem_we  <= nxt == STORE;
            done    <= nxt == DONE;
            err     <= fault;
            if (acc) begin
                mem_addr  <= data_req ? data_addr : pc;
                mem_wdata <= wdata;
            end
            // mem_addr still holds the fetch pc while the fetch is outstanding
            if (state == FETCH && mem_ready) begin
                instr  <= mem_rdata;
                old_pc <= mem_addr;
            end
            if (state == LOAD && mem_ready) rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized transactions checked against a transaction-level model
module tb_mem_access_unit;
    localparam int TO = 255;
    logic clk = 0, rst = 0;
    logic fetch_req = 0, load_req = 0, store_req = 0;
    logic [31:0] pc = 0, data_addr = 0, wdata = 0, mem_rdata = 0;
    logic mem_ready = 0;
    logic [31:0] instr, old_pc, rdata, mem_addr, mem_wdata;
    logic busy, done, err, mem_req, mem_we;
    int total = 0, bad = 0;
    logic [31:0] m_instr = 0, m_pc = 0, m_rdata = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
        .pc(pc), .data_addr(data_addr), .wdata(wdata), .instr(instr), .old_pc(old_pc), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_old_pc"}, old_pc, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_instr"}, instr, m_instr);
        chk({tag, "_old_pc"}, old_pc, m_pc);
        chk({tag, "_rdata"}, rdata, m_rdata);
    endtask

    // Called at a falling edge; returns at a falling edge with requests idle.
    task automatic txn(input string tag, input bit s, input bit l, input bit f,
                       input logic [31:0] a_pc, input logic [31:0] a_d, input logic [31:0] wd,
                       input int wait_n, input logic [31:0] rd);
        bit is_store, is_load, is_fetch;
        logic [31:0] exp_addr;
        is_store = s;
        is_load  = !s && l;
        is_fetch = !s && !l && f;
        store_req = s; load_req = l; fetch_req = f;
        pc = a_pc; data_addr = a_d; wdata = wd;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        store_req = 0; load_req = 0; fetch_req = 0; mem_ready = 0;
        if (!(is_store || is_load || is_fetch)) begin
            chk({tag, "_idle_busy"}, 32'(busy), 0);
            chk({tag, "_idle_req"}, 32'(mem_req), 0);
            chk({tag, "_idle_err"}, 32'(err), 0);
        end else if ((is_store || is_load) && a_d[1:0] != 2'b00) begin
            chk({tag, "_mis_err"}, 32'(err), 1);
            chk({tag, "_mis_busy"}, 32'(busy), 0);
            chk({tag, "_mis_req"}, 32'(mem_req), 0);
            @(negedge clk);
            chk({tag, "_mis_err_end"}, 32'(err), 0);
            chk({tag, "_mis_req_end"}, 32'(mem_req), 0);
        end else begin
            exp_addr = is_fetch ? a_pc : a_d;
            for (int c = 0; c < TO; c++) begin
                chk({tag, "_w_busy"}, 32'(busy), 1);
                chk({tag, "_w_req"}, 32'(mem_req), 1);
                chk({tag, "_w_we"}, 32'(mem_we), 32'(is_store));
                chk({tag, "_w_addr"}, mem_addr, exp_addr);
                chk({tag, "_w_wdata"}, mem_wdata, wd);
                chk({tag, "_w_done"}, 32'(done), 0);
                chk({tag, "_w_err"}, 32'(err), 0);
                mem_ready = (c == wait_n);
                mem_rdata = (c == wait_n) ? rd : $urandom;
                // stray requests while busy must be ignored
                store_req = 1'($urandom); load_req = 1'($urandom); fetch_req = 1'($urandom);
                data_addr = $urandom; pc = $urandom; wdata = $urandom;
                @(negedge clk);
                store_req = 0; load_req = 0; fetch_req = 0;
                mem_ready = 0;
                if (c == wait_n) break;
            end
            if (wait_n < TO) begin
                chk({tag, "_done"}, 32'(done), 1);
                chk({tag, "_done_req"}, 32'(mem_req), 0);
                chk({tag, "_done_busy"}, 32'(busy), 1);
                chk({tag, "_done_err"}, 32'(err), 0);
                if (is_fetch) begin m_instr = rd; m_pc = a_pc; end
                if (is_load) m_rdata = rd;
            end else begin
                chk({tag, "_to_err"}, 32'(err), 1);
                chk({tag, "_to_done"}, 32'(done), 0);
                chk({tag, "_to_req"}, 32'(mem_req), 0);
                chk({tag, "_to_busy"}, 32'(busy), 0);
            end
            @(negedge clk);
            chk({tag, "_end_done"}, 32'(done), 0);
            chk({tag, "_end_err"}, 32'(err), 0);
            chk({tag, "_end_busy"}, 32'(busy), 0);
        end
        chk_model(tag);
    endtask

    initial begin
        logic [31:0] da;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge clk);
        chk_zero("reset_held");
        rst = 1;
        txn("fetch_min", 0, 0, 1, 32'h10, 32'h0, 32'h0, 0, 32'h00500093);
        txn("store_3", 1, 0, 0, 32'h0, 32'h20, 32'hDEADBEEF, 3, 32'h12345678);
        txn("priority", 1, 1, 1, 32'h40, 32'h30, 32'hCAFEF00D, 1, 32'hA5A5A5A5);
        txn("misalign", 0, 1, 0, 32'h0, 32'h22, 32'h0, 0, 32'h0);
        txn("load_ok", 0, 1, 0, 32'h0, 32'h44, 32'h0, 2, 32'h0BADF00D);
        txn("timeout", 0, 1, 0, 32'h0, 32'h48, 32'h0, TO, 32'hFFFFFFFF);
        txn("nothing", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 60; i++) begin
            da = $urandom;
            if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
            txn("rand", 1'($urandom), 1'($urandom), 1'($urandom), $urandom, da, $urandom,
                $urandom_range(0, 6), $urandom);
        end
        load_req = 1; data_addr = 32'h50;
        @(negedge clk);
        load_req = 0;
        repeat (2) @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h13572468; rst = 0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        chk_zero("rst_mid_edge");
        rst = 1;
        @(negedge clk);
        mem_ready = 0;
        m_instr = 0; m_pc = 0; m_rdata = 0;
        chk_zero("after_rst");
        txn("post_rst", 0, 0, 1, 32'h100, 32'h0, 32'h0, 0, 32'h00A00113);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
